// File: rtl/multi_port_mem_arbiter_pkg.sv
// multi_port_mem_arbiter_pkg: default geometry and reset polarity shared by the arbitrated RAM.
// The optional MEM_BOUNDS_CHECK_EN build flags accesses whose address lies beyond DEPTH words.
package multi_port_mem_arbiter_pkg;
  localparam int NUM_PORTS_D = 3;
  localparam int DATA_W_D = 32;
  localparam int DEPTH_D = 1024;
  localparam int ADDR_W_D = 32;
  localparam logic RST_ACTIVE = 1'b0;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multi_port_mem_arbiter_if.sv
// multi_port_mem_arbiter_if: per-port request bus between requestors (master) and the shared RAM (slave).
interface multi_port_mem_arbiter_if
  import multi_port_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_D,
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D
);
  logic [NUM_PORTS-1:0] valid_in;
  logic [NUM_PORTS*ADDR_W-1:0] addr_in;
  logic [NUM_PORTS*DATA_W-1:0] wdata_in;
  logic [NUM_PORTS*(DATA_W/8)-1:0] byte_en_in;
  logic [NUM_PORTS-1:0] read_en_in;
  logic [NUM_PORTS-1:0] write_en_in;
  logic [NUM_PORTS-1:0] ready_out;
  logic [NUM_PORTS-1:0] rdata_valid_out;
  logic [NUM_PORTS*DATA_W-1:0] rdata_out;
  logic [NUM_PORTS-1:0] err_out;
  modport master (
    output valid_in, addr_in, wdata_in, byte_en_in, read_en_in, write_en_in,
    input ready_out, rdata_valid_out, rdata_out, err_out
  );
  modport slave (
    input valid_in, addr_in, wdata_in, byte_en_in, read_en_in, write_en_in,
    output ready_out, rdata_valid_out, rdata_out, err_out
  );
endinterface

// File: rtl/multi_port_mem_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the port after the last winner gets top priority.
module rr_arbiter
  import multi_port_mem_arbiter_pkg::*;
#(
  parameter int N = NUM_PORTS_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_valid,
  output logic [N-1:0] o_grant
);
  localparam int PW = ptr_w(N);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;
  always_comb begin
    int j;
    o_grant = '0;
    w_next = r_ptr;
    // walk from lowest to highest priority so the highest-priority hit is assigned last
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(r_ptr) + i) % N;
      if (i_valid[j]) begin
        o_grant = N'(1) << j;
        w_next = PW'((j + 1) % N);
      end
    end
    if (rst == RST_ACTIVE) o_grant = '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (rst == RST_ACTIVE) r_ptr <= '0;
    else if (|o_grant) r_ptr <= w_next;
endmodule

// File: rtl/multi_port_mem_arbiter.sv
// multi_port_mem_arbiter: single-port RAM shared by NUM_PORTS requestors with round-robin grant
// and registered per-port read data. MEM_BOUNDS_CHECK_EN enables out-of-range detection.
module multi_port_mem_arbiter
  import multi_port_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_D,
  parameter int DATA_W = DATA_W_D,
  parameter int DEPTH = DEPTH_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input logic clk,
  input logic rst,
  multi_port_mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int OFF = $clog2(BE_W);
  localparam int IW = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [NUM_PORTS-1:0] w_grant;
  logic [NUM_PORTS-1:0] r_rvalid;
  logic [NUM_PORTS*DATA_W-1:0] r_rdata;
  logic [IW-1:0] w_idx;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0] w_be;
  logic w_rd;
  logic w_wr;
  logic w_oob;
  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk(clk),
    .rst(rst),
    .i_valid(bus.valid_in),
    .o_grant(w_grant)
  );
  assign bus.ready_out = w_grant;
  assign bus.rdata_valid_out = r_rvalid;
  assign bus.rdata_out = r_rdata;
  assign w_rd = |(w_grant & bus.read_en_in);
  assign w_wr = |(w_grant & bus.write_en_in);
  always_comb begin
    w_idx = '0;
    w_wdata = '0;
    w_be = '0;
    w_oob = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (w_grant[p]) begin
        w_idx = bus.addr_in[p*ADDR_W+OFF +: IW];
        w_wdata = bus.wdata_in[p*DATA_W +: DATA_W];
        w_be = bus.byte_en_in[p*BE_W +: BE_W];
`ifdef MEM_BOUNDS_CHECK_EN
        w_oob = |(bus.addr_in[p*ADDR_W +: ADDR_W] >> (IW + OFF));
`endif
      end
  end
  always_ff @(posedge clk)
    if (w_wr && !w_oob)
      for (int b = 0; b < BE_W; b++)
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
  // the read samples the array before this edge's write lands: read-before-write
  always_ff @(posedge clk or negedge rst)
    if (rst == RST_ACTIVE) begin
      r_rvalid <= '0;
      r_rdata <= '0;
    end else begin
      r_rvalid <= w_rd ? w_grant : '0;
      for (int p = 0; p < NUM_PORTS; p++)
        if (w_rd && w_grant[p]) r_rdata[p*DATA_W +: DATA_W] <= w_oob ? '0 : r_mem[w_idx];
    end
`ifdef MEM_BOUNDS_CHECK_EN
  logic [NUM_PORTS-1:0] r_err;
  always_ff @(posedge clk or negedge rst)
    if (rst == RST_ACTIVE) r_err <= '0;
    else r_err <= w_oob ? w_grant : '0;
  assign bus.err_out = r_err;
`else
  assign bus.err_out = '0;
`endif
endmodule
